// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the core run controller
package cpu_pkg;

  localparam int PC_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIN,
    ERR
  } run_state_t;

  localparam logic [PC_W-1:0] PROG_BASE [0:3] = '{10'd0, 10'd256, 10'd512, 10'd768};

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - start/done handshake and core control bundle
interface cpu_run_ctrl_if #(
  parameter int D  = 10,
  parameter int P  = 2,
  parameter int CW = 16
);

  logic          req;
  logic [P-1:0]  prog_sel;
  logic          halt;
  logic          core_reset;
  logic          core_run;
  logic [D-1:0]  start_addr;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  modport master (
    output req, prog_sel, halt,
    input  core_reset, core_run, start_addr, busy, done, timeout, cycles
  );

  modport slave (
    input  req, prog_sel, halt,
    output core_reset, core_run, start_addr, busy, done, timeout, cycles
  );

endinterface

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating RUN cycle counter with timeout compare
module run_watchdog #(
  parameter int          CW      = 16,
  parameter int unsigned TIMEOUT = 16'hFFF0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          expire
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the last allowed cycle so the counter lands exactly on TIMEOUT.
  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/sequence controller for the single-cycle core
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int          D        = 10,
  parameter int          P        = 2,
  parameter int          INIT_CYC = 2,
  parameter int          CW       = 16,
  parameter int unsigned TIMEOUT  = 16'hFFF0
) (
  input  logic            clk,
  input  logic            reset,
  cpu_run_ctrl_if.slave   bus
);

  localparam int IW = $clog2(INIT_CYC + 1);

  run_state_t    state, state_n;
  logic          req_q;
  logic          start;
  logic          load_go;
  logic [IW-1:0] init_cnt, init_n;
  logic          core_reset_q, core_reset_n;
  logic          core_run_q, core_run_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          timeout_q, timeout_n;
  logic [D-1:0]  start_addr_q, start_addr_n;
  logic          wd_clr;
  logic          wd_en;
  logic          wd_expire;
  logic [CW-1:0] wd_count;

  assign start   = bus.req & ~req_q;
  assign load_go = start && ((state == IDLE) || (state == FIN) || (state == ERR));
  assign wd_clr  = reset | load_go;

  run_watchdog #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .clr    (wd_clr),
    .en     (wd_en),
    .count  (wd_count),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    // Tracks req through reset too, so a level already high at release is not a start.
    req_q <= bus.req;
    if (reset) begin
      state        <= IDLE;
      init_cnt     <= '0;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      start_addr_q <= '0;
    end else begin
      state        <= state_n;
      init_cnt     <= init_n;
      core_reset_q <= core_reset_n;
      core_run_q   <= core_run_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      timeout_q    <= timeout_n;
      start_addr_q <= start_addr_n;
    end
  end

  always_comb begin
    state_n      = state;
    init_n       = init_cnt;
    core_reset_n = core_reset_q;
    core_run_n   = core_run_q;
    busy_n       = busy_q;
    done_n       = done_q;
    timeout_n    = timeout_q;
    start_addr_n = start_addr_q;
    wd_en        = 1'b0;

    case (state)
      IDLE: begin
        core_reset_n = 1'b1;
        core_run_n   = 1'b0;
      end
      LOAD: begin
        init_n = init_cnt + 1'b1;
        if (init_cnt == IW'(INIT_CYC - 1)) begin
          state_n      = RUN;
          core_reset_n = 1'b0;
          core_run_n   = 1'b1;
        end
      end
      RUN: begin
        wd_en = 1'b1;
        if (bus.halt) begin
          state_n    = FIN;
          core_run_n = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end else if (wd_expire) begin
          state_n    = ERR;
          core_run_n = 1'b0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
        end
      end
      FIN, ERR: begin
        core_run_n = 1'b0;
        busy_n     = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Common entry into LOAD from any resting state.
    if (load_go) begin
      state_n      = LOAD;
      init_n       = '0;
      start_addr_n = D'(PROG_BASE[bus.prog_sel]);
      core_reset_n = 1'b1;
      core_run_n   = 1'b0;
      busy_n       = 1'b1;
      done_n       = 1'b0;
      timeout_n    = 1'b0;
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.core_run   = core_run_q;
  assign bus.start_addr = start_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycles     = wd_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed table-driven bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  typedef struct packed {
    logic        cr;
    logic        run;
    logic        busy;
    logic        done;
    logic        to;
    logic [9:0]  sa;
    logic [15:0] cyc;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [1:0] ps;
    logic       halt;
    outs_t      exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  vec_t  vecs[$];
  outs_t got;
  int    checks = 0;
  int    errors = 0;

  cpu_run_ctrl_if #(.D(10), .P(2), .CW(16)) bus ();

  cpu_run_ctrl #(
    .D        (10),
    .P        (2),
    .INIT_CYC (2),
    .CW       (16),
    .TIMEOUT  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic v(input logic rst, input logic req, input logic [1:0] ps, input logic halt,
                   input logic cr, input logic run, input logic busy, input logic done,
                   input logic to, input logic [9:0] sa, input logic [15:0] cyc);
    vec_t r;
    r.rst = rst; r.req = req; r.ps = ps; r.halt = halt;
    r.exp = '{cr: cr, run: run, busy: busy, done: done, to: to, sa: sa, cyc: cyc};
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.cr = bus.core_reset; o.run = bus.core_run; o.busy = bus.busy; o.done = bus.done;
    o.to = bus.timeout; o.sa = bus.start_addr; o.cyc = bus.cycles;
    return o;
  endfunction

  initial begin
    int n;
    reset = 1'b1; bus.req = 1'b1; bus.prog_sel = '0; bus.halt = 1'b0;

    // Reset held with req high; release with req still high must not start.
    repeat (3) v(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // prog_sel=2, halt on the 5th RUN cycle
    v(0, 1, 2, 0, 1, 0, 1, 0, 0, 512, 0);
    v(0, 1, 2, 0, 1, 0, 1, 0, 0, 512, 0);
    v(0, 1, 2, 0, 0, 1, 1, 0, 0, 512, 0);
    for (int k = 1; k <= 4; k++) v(0, 1, 2, 0, 0, 1, 1, 0, 0, 512, 16'(k));
    v(0, 1, 2, 1, 0, 0, 0, 1, 0, 512, 5);
    v(0, 0, 2, 1, 0, 0, 0, 1, 0, 512, 5);
    // Restart from FIN with prog_sel=1; req toggles in LOAD and RUN ignored
    v(0, 1, 1, 0, 1, 0, 1, 0, 0, 256, 0);
    v(0, 0, 1, 0, 1, 0, 1, 0, 0, 256, 0);
    v(0, 1, 3, 0, 0, 1, 1, 0, 0, 256, 0);
    v(0, 0, 3, 0, 0, 1, 1, 0, 0, 256, 1);
    v(0, 1, 0, 0, 0, 1, 1, 0, 0, 256, 2);
    v(0, 1, 0, 1, 0, 0, 0, 1, 0, 256, 3);
    // Watchdog abort after 8 RUN cycles
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 256, 3);
    v(0, 1, 3, 0, 1, 0, 1, 0, 0, 768, 0);
    v(0, 1, 3, 0, 1, 0, 1, 0, 0, 768, 0);
    v(0, 1, 3, 0, 0, 1, 1, 0, 0, 768, 0);
    for (int k = 1; k <= 7; k++) v(0, 1, 3, 0, 0, 1, 1, 0, 0, 768, 16'(k));
    v(0, 1, 3, 0, 0, 0, 0, 1, 1, 768, 8);
    v(0, 1, 3, 1, 0, 0, 0, 1, 1, 768, 8);
    // Restart from ERR; halt coincides with the timeout cycle -> FIN
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 768, 8);
    v(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) v(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 16'(k));
    v(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 8);
    // Reset on RUN cycle 3
    v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8);
    v(0, 1, 1, 0, 1, 0, 1, 0, 0, 256, 0);
    v(0, 1, 1, 0, 1, 0, 1, 0, 0, 256, 0);
    v(0, 1, 1, 0, 0, 1, 1, 0, 0, 256, 0);
    v(0, 1, 1, 0, 0, 1, 1, 0, 0, 256, 1);
    v(0, 1, 1, 0, 0, 1, 1, 0, 0, 256, 2);
    v(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; bus.req = vecs[i].req;
      bus.prog_sel = vecs[i].ps; bus.halt = vecs[i].halt;
      @(posedge clk);
      #1;
      got = sample();
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL row %0d: got cr=%b run=%b busy=%b done=%b to=%b sa=%0d cyc=%0d, expected cr=%b run=%b busy=%b done=%b to=%b sa=%0d cyc=%0d",
                 i, got.cr, got.run, got.busy, got.done, got.to, got.sa, got.cyc,
                 vecs[i].exp.cr, vecs[i].exp.run, vecs[i].exp.busy, vecs[i].exp.done,
                 vecs[i].exp.to, vecs[i].exp.sa, vecs[i].exp.cyc);
      end
    end

    // Start-to-run latency, halt-to-done latency, core stays frozen after halt
    @(negedge clk); bus.req = 1'b0; bus.halt = 1'b0;
    @(negedge clk); bus.req = 1'b1; bus.prog_sel = 2'd2;
    @(posedge clk); #1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.core_run && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("run_latency", 32'(n), 32'd2);
    check("start_addr", 32'(bus.start_addr), 32'd512);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); bus.halt = 1'b0;
      @(posedge clk);
    end
    @(negedge clk); bus.halt = 1'b1;
    @(posedge clk); #1;
    check("done_after_halt", 32'(bus.done), 32'd1);
    check("cycles_at_halt", 32'(bus.cycles), 32'd3);
    check("busy_after_halt", 32'(bus.busy), 32'd0);
    @(negedge clk); bus.halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("run_frozen", 32'(bus.core_run), 32'd0);
      check("done_held", 32'(bus.done), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
